// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC = 32'h0;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue_if.sv
// PC-stage, instruction-memory and decode signals of the fetch queue.
interface ifetch_queue_if;
   import fetch_pkg::*;

   logic [XLEN-1:0] pc_in;
   logic            pc_valid;
   logic            pc_ready;
   logic            flush;
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic [XLEN-1:0] imem_rdata;
   logic            inst_valid;
   logic [XLEN-1:0] inst_data;
   logic [XLEN-1:0] inst_pc;
   logic            inst_ready;

   // master: the fetch queue itself (it masters the memory request bus)
   modport master (
      input  pc_in, pc_valid, flush, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
      output pc_ready, imem_req, imem_addr, inst_valid, inst_data, inst_pc
   );

   // slave: PC stage, instruction memory and decode around the queue
   modport slave (
      output pc_in, pc_valid, flush, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
      input  pc_ready, imem_req, imem_addr, inst_valid, inst_data, inst_pc
   );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear; head word is visible combinationally.
module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             clear_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;
   assign rdata_o = mem_q[rptr_q];

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear_i) mem_q[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch front end: in-order imem requests under a credit limit, tag/instruction
// buffering, and flush handling that drops responses still in flight.
module ifetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   ifetch_queue_if.master fe_if
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [CW-1:0] tag_count, inst_count;
   logic [CW:0]   in_use;
   logic          tag_full, tag_empty, inst_full, inst_empty;
   logic          credit_ok, grant, rsp, discard;
   logic [XLEN-1:0] tag_head;
   fetch_entry_t  inst_wr, inst_rd;
   logic          unused_fifo;

   assign in_use    = {1'b0, outstanding_q} + {1'b0, inst_count};
   assign credit_ok = (in_use < (CW + 1)'(DEPTH));

   assign fe_if.imem_req  = fe_if.pc_valid & credit_ok & ~fe_if.flush;
   assign fe_if.imem_addr = fe_if.pc_in;
   assign grant           = fe_if.imem_req & fe_if.imem_gnt;
   assign fe_if.pc_ready  = grant;

   // a response with nothing outstanding is a stray and must not touch state
   assign rsp     = fe_if.imem_rvalid & (outstanding_q != '0);
   assign discard = rsp & (fe_if.flush | (drop_q != '0));

   assign inst_wr = '{pc: tag_head, inst: fe_if.imem_rdata};

   assign fe_if.inst_valid = ~inst_empty;
   assign fe_if.inst_data  = inst_empty ? '0 : inst_rd.inst;
   assign fe_if.inst_pc    = inst_empty ? '0 : inst_rd.pc;

   assign unused_fifo = ^{tag_count, tag_empty, tag_full, inst_full};

   fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (grant),
      .pop_i   (rsp),
      .clear_i (1'b0),
      .wdata_i (fe_if.pc_in),
      .rdata_o (tag_head),
      .full_o  (tag_full),
      .empty_o (tag_empty),
      .count_o (tag_count)
   );

   fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_inst_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (rsp & ~discard),
      .pop_i   (fe_if.inst_valid & fe_if.inst_ready),
      .clear_i (fe_if.flush),
      .wdata_i (inst_wr),
      .rdata_o (inst_rd),
      .full_o  (inst_full),
      .empty_o (inst_empty),
      .count_o (inst_count)
   );

   always_comb begin
      outstanding_d = outstanding_q;
      if (grant && !rsp)
         outstanding_d = outstanding_q + CW'(1);
      else if (!grant && rsp)
         outstanding_d = outstanding_q - CW'(1);

      // on flush, everything still in flight after this cycle's response is dropped
      drop_d = drop_q;
      if (fe_if.flush)
         drop_d = outstanding_q - CW'(rsp);
      else if (rsp && drop_q != '0)
         drop_d = drop_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized + directed bench for ifetch_queue with a queue-based reference model.
module tb_ifetch_queue;
   import fetch_pkg::*;

   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] pc;
      bit          drop;
   } flight_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ifetch_queue_if bus();

   ifetch_queue #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .fe_if (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int dut_grants = 0;

   flight_t     flight_q[$];
   logic [63:0] exp_q[$];
   logic [31:0] deliv_pcs[$];
   logic [31:0] mem_img [logic [31:0]];
   logic [31:0] pc_cur = 32'h0;
   logic [63:0] mon_e;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   function automatic logic [31:0] mem_word(logic [31:0] a);
      if (mem_img.exists(a)) return mem_img[a];
      return (a * 32'h9E3779B1) ^ 32'h0000_0013;
   endfunction

   // one clock cycle: drive, check combinational outputs, then advance the model
   task automatic cycle(bit pv, bit gnt, bit rv, bit rdy, bit fl, bit r);
      bit      exp_req;
      flight_t f;
      @(posedge clk); #1;
      rst              = r;
      bus.pc_valid     = pv;
      bus.pc_in        = pc_cur;
      bus.flush        = fl;
      bus.imem_gnt     = gnt;
      bus.imem_rvalid  = rv;
      bus.imem_rdata   = (flight_q.size() > 0) ? mem_word(flight_q[0].pc) : $urandom();
      bus.inst_ready   = rdy && !fl;
      #1;
      if (r) begin
         @(negedge clk); #1;
         flight_q.delete();
         exp_q.delete();
         return;
      end
      exp_req = pv && !fl && ((flight_q.size() + exp_q.size()) < DEPTH);
      chk("imem_req", bus.imem_req, exp_req);
      chk("imem_addr", bus.imem_addr, pc_cur);
      chk("pc_ready", bus.pc_ready, exp_req && gnt);
      if (bus.pc_ready) dut_grants++;
      @(negedge clk); #1;
      if (rv && flight_q.size() > 0) begin
         f = flight_q.pop_front();
         if (!(f.drop || fl)) exp_q.push_back({f.pc, mem_word(f.pc)});
      end
      if (fl) begin
         exp_q.delete();
         foreach (flight_q[i]) flight_q[i].drop = 1'b1;
      end
      if (exp_req && gnt) begin
         flight_q.push_back('{pc: pc_cur, drop: 1'b0});
         $display("grant pc=%h", pc_cur);
         pc_cur += 32'd4;
      end
   endtask

   task automatic drain();
      repeat (12) cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   // monitor: pops the scoreboard whenever decode accepts an instruction
   always @(negedge clk) begin
      if (!rst) begin
         chk("inst_valid", bus.inst_valid, exp_q.size() != 0);
         if (!bus.inst_valid) begin
            chk("idle_outputs", {bus.inst_pc, bus.inst_data}, 64'h0);
         end else if (bus.inst_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL inst_extra: got pc=%h expected no instruction", bus.inst_pc);
            end else begin
               mon_e = exp_q.pop_front();
               chk("inst", {bus.inst_pc, bus.inst_data}, mon_e);
               deliv_pcs.push_back(bus.inst_pc);
               $display("deliver pc=%h inst=%h", bus.inst_pc, bus.inst_data);
            end
         end
      end
   end

   initial begin
      int g0;
      bus.pc_valid = 1'b0; bus.pc_in = '0; bus.flush = 1'b0; bus.imem_gnt = 1'b0;
      bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.inst_ready = 1'b0;
      mem_img[32'h0] = 32'h00500093;
      mem_img[32'h4] = 32'h00100113;
      mem_img[32'h8] = 32'h002081B3;

      repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // stream
      pc_cur = 32'h0;
      deliv_pcs.delete();
      cycle(1, 1, 0, 1, 0, 0);
      cycle(1, 1, 1, 1, 0, 0);
      cycle(1, 1, 1, 1, 0, 0);
      cycle(0, 1, 1, 1, 0, 0);
      drain();
      chk("stream_count", deliv_pcs.size(), 3);
      if (deliv_pcs.size() == 3) chk("stream_pc2", deliv_pcs[2], 32'h8);

      // backpressure
      g0 = dut_grants;
      repeat (10) cycle(1, 1, 1, 0, 0, 0);
      chk("bp_grants", dut_grants - g0, 4);
      repeat (6) cycle(1, 1, 1, 1, 0, 0);
      drain();

      // grant stall
      pc_cur = 32'h10;
      g0 = dut_grants;
      repeat (3) cycle(1, 0, 0, 1, 0, 0);
      cycle(1, 1, 0, 1, 0, 0);
      chk("stall_grants", dut_grants - g0, 1);
      drain();

      // flush with 2 outstanding and 1 buffered
      pc_cur = 32'h20;
      cycle(1, 1, 0, 0, 0, 0);
      cycle(1, 1, 1, 0, 0, 0);
      cycle(1, 1, 0, 0, 0, 0);
      pc_cur = 32'h40;
      deliv_pcs.delete();
      cycle(1, 1, 0, 0, 1, 0);
      cycle(0, 1, 1, 1, 0, 0);
      cycle(0, 1, 1, 1, 0, 0);
      cycle(1, 1, 0, 1, 0, 0);
      drain();
      chk("flush_count", deliv_pcs.size(), 1);
      if (deliv_pcs.size() > 0) chk("flush_first_pc", deliv_pcs[0], 32'h40);

      // flush coinciding with a response, 3 outstanding
      pc_cur = 32'h60;
      repeat (3) cycle(1, 1, 0, 0, 0, 0);
      pc_cur = 32'h80;
      deliv_pcs.delete();
      cycle(0, 1, 1, 0, 1, 0);
      cycle(1, 1, 0, 1, 0, 0);
      repeat (3) cycle(0, 1, 1, 1, 0, 0);
      drain();
      chk("coinc_count", deliv_pcs.size(), 1);
      if (deliv_pcs.size() > 0) chk("coinc_pc", deliv_pcs[0], 32'h80);

      // reset mid-operation, then stray responses
      pc_cur = 32'hA0;
      repeat (4) cycle(1, 1, 0, 0, 0, 0);
      repeat (2) cycle(0, 1, 1, 0, 0, 0);
      deliv_pcs.delete();
      cycle(0, 0, 1, 0, 0, 1);
      repeat (4) cycle(0, 0, 1, 1, 0, 0);
      chk("rst_no_deliveries", deliv_pcs.size(), 0);
      cycle(1, 1, 0, 1, 0, 0);
      drain();

      // random traffic
      for (int n = 0; n < 1500; n++) begin
         bit pv, gnt, rv, rdy, fl, r;
         pv  = ($urandom_range(0, 3) != 0);
         gnt = ($urandom_range(0, 9) < 7);
         rv  = (flight_q.size() > 0) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 19) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         fl  = ($urandom_range(0, 29) == 0);
         r   = ($urandom_range(0, 299) == 0);
         if (fl) pc_cur = $urandom() & 32'hFFFF_FFFC;
         cycle(pv, gnt, rv, rdy, fl, r);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
